complex_mean_square_framer: RTL

- Upstream feeder for the complex mean-square unit.
- Accepts (y, y_hat) complex sample pairs from a bursty producer through a valid/ready handshake and buffers them in an internal FIFO.
- Emits frames of exactly 2^log2_samples beats on consecutive cycles. The mean-square stage has no backpressure and needs gap-free frames.
- Optionally holds off the next frame until that stage reports its result.

---
 rtl/complex_mean_square_framer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/complex_mean_square_framer.sv
// Purpose : buffers (y, y_hat) complex sample pairs and emits gap-free frames of 2^log2 beats.
// Latency : a frame starts 2 cycles after the FIFO count reaches N (FILL -> BURST -> first beat).
// Backpress: input side valid/ready (ready = FIFO not full); output side has none, frames never stall.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_en, i_log2_samples  frame enable and length, sampled in IDLE only
//   i_valid/o_ready       input handshake for i_y, i_y_hat
//   i_result_valid        result pulse from the mean-square stage, releases WAIT
//   o_valid/o_first/o_last, o_y, o_y_hat   framed output beats
//   o_busy, o_frame_cnt   state != IDLE, completed frame count (wraps)

module complex_mean_square_framer_fifo #(
    parameter int W  = 64,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_vld,
    output logic          wr_rdy,
    input  logic [W-1:0]  wr_dat,
    input  logic          rd_rdy,
    output logic [W-1:0]  rd_dat,
    output logic [AW:0]   count
);
    // Purpose : generic single-clock FIFO, show-ahead read data.
    // Latency : written entry readable the cycle after the push.
    // Backpress: wr_rdy from registered count; caller must not pop when empty.

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;

    // Full blocks a push even when a pop happens in the same cycle.
    assign wr_rdy = (count != FULL);
    assign push   = wr_vld && wr_rdy;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_rdy) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, rd_rdy})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module complex_mean_square_framer #(
    parameter int DATA_W      = 32,
    parameter int FIFO_AW     = 7,
    parameter bit WAIT_RESULT = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [2:0]        i_log2_samples,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_y,
    input  logic [DATA_W-1:0] i_y_hat,
    input  logic              i_result_valid,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_y,
    output logic [DATA_W-1:0] o_y_hat,
    output logic              o_first,
    output logic              o_last,
    output logic              o_busy,
    output logic [15:0]       o_frame_cnt
);
    localparam int ENTRY_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_BURST = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t               state;
    logic [2:0]           log2_n;
    logic [7:0]           n_len;
    logic [7:0]           beat_cnt;
    logic                 pop;
    logic [ENTRY_W-1:0]   rd_dat;
    logic [FIFO_AW:0]     count;

    complex_mean_square_framer_fifo #(
        .W  (ENTRY_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk    (i_clk),
        .rst    (i_rst),
        .wr_vld (i_valid),
        .wr_rdy (o_ready),
        .wr_dat ({i_y, i_y_hat}),
        .rd_rdy (pop),
        .rd_dat (rd_dat),
        .count  (count)
    );

    // Frame length comes from the value latched at frame start, so a change
    // on i_log2_samples during a burst cannot shorten the frame in flight.
    assign n_len  = 8'd1 << log2_n;
    // BURST is only entered once N entries are buffered, so popping every
    // BURST cycle can never underflow and the frame has no gaps.
    assign pop    = (state == S_BURST);
    assign o_busy = (state != S_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            log2_n      <= '0;
            beat_cnt    <= '0;
            o_valid     <= 1'b0;
            o_first     <= 1'b0;
            o_last      <= 1'b0;
            o_y         <= '0;
            o_y_hat     <= '0;
            o_frame_cnt <= '0;
        end else begin
            // Output stage: one register slot behind the pop.
            o_valid <= pop;
            o_first <= 1'b0;
            o_last  <= 1'b0;
            if (pop) begin
                o_y     <= rd_dat[ENTRY_W-1:DATA_W];
                o_y_hat <= rd_dat[DATA_W-1:0];
                o_first <= (beat_cnt == n_len - 8'd1);
                o_last  <= (beat_cnt == 8'd0);
                if (beat_cnt == 8'd0) begin
                    o_frame_cnt <= o_frame_cnt + 16'd1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (i_en) begin
                        log2_n <= i_log2_samples;
                        state  <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (32'(count) >= 32'(n_len)) begin
                        beat_cnt <= n_len - 8'd1;
                        state    <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (beat_cnt == 8'd0) begin
                        state <= WAIT_RESULT ? S_WAIT : S_IDLE;
                    end else begin
                        beat_cnt <= beat_cnt - 8'd1;
                    end
                end
                S_WAIT: begin
                    if (i_result_valid) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
